// File: rtl/tick_gen_pkg.sv
// Purpose: shared constants and helpers for the multi-rate tick generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tick_gen_pkg;

  // Rate codes as seen on rate_sel. Two codes select divide-by-64, and the
  // top code selects the per-channel custom divisor register.
  typedef enum logic [2:0] {
    RATE_DIV64     = 3'd0,
    RATE_DIV32     = 3'd1,
    RATE_DIV16     = 3'd2,
    RATE_DIV8      = 3'd3,
    RATE_DIV4      = 3'd4,
    RATE_DIV2      = 3'd5,
    RATE_DIV64_ALT = 3'd6,
    RATE_CUSTOM    = 3'd7
  } rate_e;

  // Divisor loaded at reset and reset value of the custom registers.
  localparam int unsigned DIV_DEFAULT = 64;
  // Smallest divisor that still leaves room for a distinct mid-bit point.
  localparam int unsigned DIV_MIN = 2;
  // Code that selects the custom register instead of the fixed table.
  localparam logic [2:0] RATE_CODE_CUSTOM = 3'd7;

  // Fixed part of the rate table. The custom code never reaches a caller
  // through this function in normal use; it falls back to the default.
  function automatic int unsigned rate_table(input logic [2:0] code);
    int unsigned div;
    case (rate_e'(code))
      RATE_DIV64:     div = 64;
      RATE_DIV32:     div = 32;
      RATE_DIV16:     div = 16;
      RATE_DIV8:      div = 8;
      RATE_DIV4:      div = 4;
      RATE_DIV2:      div = 2;
      RATE_DIV64_ALT: div = 64;
      default:        div = DIV_DEFAULT;
    endcase
    return div;
  endfunction

  // Raise any divisor below the minimum up to the minimum.
  function automatic int unsigned clamp_div(input int unsigned div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// Purpose: one channel of the tick generator: bit-phase counter, bit counter,
//          bit/mid/frame pulses, divisor latched only at bit boundaries.
// Latency: every pulse is registered, one clock after its counter match.
// Backpressure: none; the channel free-runs while enable_i is high.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable_i          run enable; low clears counters and idles the channel
//   rate_sel_i        3-bit rate code
//   frame_len_i       bits per frame, 0 disables frame_done_o
//   cust_div_i        custom divisor (already clamped), used for code 7
//   bit_tick_o        pulse at each bit boundary
//   mid_tick_o        pulse at the mid-bit sampling point
//   frame_done_o      pulse together with the last bit_tick_o of a frame
//   busy_o            high while the counter is running
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int DIV_W   = 12,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic [2:0]         rate_sel_i,
  input  logic [FRAME_W-1:0] frame_len_i,
  input  logic [DIV_W-1:0]   cust_div_i,
  output logic               bit_tick_o,
  output logic               mid_tick_o,
  output logic               frame_done_o,
  output logic               busy_o
);

  logic [DIV_W-1:0]   act_div_q, act_div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] bits_q, bits_d;
  logic               busy_q, busy_d;
  logic               bit_tick_q, bit_tick_d;
  logic               mid_tick_q, mid_tick_d;
  logic               frame_done_q, frame_done_d;

  logic [DIV_W-1:0]   div_map;
  logic [DIV_W-1:0]   eff_div;
  logic               bit_match;
  logic               mid_match;
  logic               frame_last;

  // Divisor currently requested by the inputs.
  assign div_map = (rate_sel_i == RATE_CODE_CUSTOM) ? cust_div_i
                                                    : DIV_W'(rate_table(rate_sel_i));

  // On the very first enabled cycle (busy_q still low) the bit is just
  // starting, so the requested divisor applies directly. This keeps the
  // first tick act_div clocks after enable even straight out of reset,
  // when act_div_q still holds the reset default.
  assign eff_div = busy_q ? act_div_q : div_map;

  assign bit_match  = (cnt_q == (eff_div - DIV_W'(1)));
  // For a divisor of 2 this resolves to cnt 0; odd divisors round down.
  assign mid_match  = (cnt_q == ((eff_div >> 1) - DIV_W'(1)));
  assign frame_last = (frame_len_i != '0) && (bits_q == (frame_len_i - FRAME_W'(1)));

  always_comb begin
    act_div_d    = act_div_q;
    cnt_d        = cnt_q;
    bits_d       = bits_q;
    busy_d       = busy_q;
    bit_tick_d   = 1'b0;
    mid_tick_d   = 1'b0;
    frame_done_d = 1'b0;

    if (!enable_i) begin
      // Idle: track the requested divisor so a later start uses it, and
      // drop any tick whose match lands on this cycle.
      cnt_d     = '0;
      bits_d    = '0;
      busy_d    = 1'b0;
      act_div_d = div_map;
    end else begin
      busy_d    = 1'b1;
      act_div_d = eff_div;
      mid_tick_d = mid_match;
      if (bit_match) begin
        // Bit boundary: the only point where a new divisor takes effect.
        cnt_d      = '0;
        bit_tick_d = 1'b1;
        act_div_d  = div_map;
        if (frame_last) begin
          frame_done_d = 1'b1;
          bits_d       = '0;
        end else begin
          // Free-running wrap when no frame length is configured.
          bits_d = bits_q + FRAME_W'(1);
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_div_q    <= DIV_W'(DIV_DEFAULT);
      cnt_q        <= '0;
      bits_q       <= '0;
      busy_q       <= 1'b0;
      bit_tick_q   <= 1'b0;
      mid_tick_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      act_div_q    <= act_div_d;
      cnt_q        <= cnt_d;
      bits_q       <= bits_d;
      busy_q       <= busy_d;
      bit_tick_q   <= bit_tick_d;
      mid_tick_q   <= mid_tick_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bit_tick_o   = bit_tick_q;
  assign mid_tick_o   = mid_tick_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;

endmodule

// File: rtl/multi_rate_tick_gen.sv
// Purpose: NCH independent bit-rate tick generators with a shared write port
//          for per-channel custom divisors.
// Latency: ticks are registered (one clock after match); cfg_ack one clock
//          after an accepted write.
// Backpressure: none; a write is accepted every cycle it targets a valid channel.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   enable[NCH]                  per-channel run enable
//   rate_sel[3*NCH]              per-channel rate code, channel i at [3i+2:3i]
//   frame_len[FRAME_W*NCH]       per-channel bits per frame (0 = no frame_done)
//   cfg_wr, cfg_ch, cfg_div      custom-divisor write port
//   cfg_ack                      acknowledge of an accepted write
//   bit_tick, mid_tick,
//   frame_done, busy [NCH]       per-channel status pulses / level
module multi_rate_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DIV_W   = 12,
  parameter int FRAME_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         enable,
  input  logic [3*NCH-1:0]       rate_sel,
  input  logic [FRAME_W*NCH-1:0] frame_len,
  input  logic                   cfg_wr,
  input  logic [3:0]             cfg_ch,
  input  logic [DIV_W-1:0]       cfg_div,
  output logic                   cfg_ack,
  output logic [NCH-1:0]         bit_tick,
  output logic [NCH-1:0]         mid_tick,
  output logic [NCH-1:0]         frame_done,
  output logic [NCH-1:0]         busy
);

  logic [DIV_W-1:0] cust_q [NCH];
  logic [DIV_W-1:0] cust_d [NCH];
  logic             cfg_ack_q, cfg_ack_d;
  logic             cfg_hit;
  logic [DIV_W-1:0] cfg_div_clamped;

  // Writes to channel numbers beyond the instantiated set are dropped
  // silently: no register changes and no acknowledge.
  assign cfg_hit = cfg_wr && ({1'b0, cfg_ch} < 5'(NCH));

  // Store the clamped value so every reader sees a legal divisor.
  assign cfg_div_clamped = DIV_W'(clamp_div(int'(cfg_div)));

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cust_d[i] = cust_q[i];
      if (cfg_hit && (cfg_ch == 4'(i))) begin
        cust_d[i] = cfg_div_clamped;
      end
    end
    cfg_ack_d = cfg_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cust_q[i] <= DIV_W'(DIV_DEFAULT);
      end
      cfg_ack_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cust_q[i] <= cust_d[i];
      end
      cfg_ack_q <= cfg_ack_d;
    end
  end

  assign cfg_ack = cfg_ack_q;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    tick_chan #(
      .DIV_W   (DIV_W),
      .FRAME_W (FRAME_W)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable_i     (enable[g]),
      .rate_sel_i   (rate_sel[3*g +: 3]),
      .frame_len_i  (frame_len[FRAME_W*g +: FRAME_W]),
      .cust_div_i   (cust_q[g]),
      .bit_tick_o   (bit_tick[g]),
      .mid_tick_o   (mid_tick[g]),
      .frame_done_o (frame_done[g]),
      .busy_o       (busy[g])
    );
  end

endmodule
